// File: rtl/zx_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zx_mem_pkg
// Description : Shared constants for the Spectrum memory mapper. Holds the
//               machine-mode codes, the divMMC automap state type, the
//               automap entry-point addresses and the +2A/+3 all-RAM
//               ("special") slot table.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package zx_mem_pkg;

    localparam logic [1:0] MODE_48   = 2'd0;
    localparam logic [1:0] MODE_128  = 2'd1;
    localparam logic [1:0] MODE_P2A  = 2'd2;
    localparam logic [1:0] MODE_PENT = 2'd3;

    typedef enum logic [1:0] {
        AM_IDLE   = 2'd0,
        AM_ARMED  = 2'd1,
        AM_MAPPED = 2'd2,
        AM_UNARM  = 2'd3
    } am_state_e;

    localparam int AM_ENTRY_N = 6;
    localparam logic [AM_ENTRY_N-1:0][15:0] AM_ENTRY = {
        16'h0562, 16'h04C6, 16'h0066, 16'h0038, 16'h0008, 16'h0000
    };

    localparam logic [7:0] DIV_PORT = 8'hE3;

    // Special-mode page per [config][slot]; outer index is the 1FFD config,
    // inner index is the 16K slot (a[15:14]). Literals list slot 3 first.
    localparam logic [3:0][3:0][2:0] SPECIAL_MAP = {
        {3'd3, 3'd6, 3'd7, 3'd4},   // config 11: 4,7,6,3
        {3'd3, 3'd6, 3'd5, 3'd4},   // config 10: 4,5,6,3
        {3'd7, 3'd6, 3'd5, 3'd4},   // config 01: 4,5,6,7
        {3'd3, 3'd2, 3'd1, 3'd0}    // config 00: 0,1,2,3
    };

    function automatic logic [2:0] special_page(input logic [1:0] cfg,
                                                input logic [1:0] slot);
        return SPECIAL_MAP[cfg][slot];
    endfunction

endpackage
`default_nettype wire

// File: rtl/zx_memory_mapper_divmmc_automap.sv
`default_nettype none
// ============================================================================
// Module      : divmmc_automap
// Description : divMMC control port (E3) register and automap state machine.
//               Entry-point fetches arm the mapper (mapping takes effect once
//               M1 returns high); 3Dxx fetches map immediately; 1FF8-1FFF
//               fetches unmap once M1 returns high.
// Ports       : clock_i, reset_i (sync clear), ce_i, Z80 strobes (active-low),
//               a_i/d_i bus; conmem_o, mapram_o, bank_o, automap_o.
// Revision    : 1.0  initial release
// ============================================================================
module divmmc_automap
    import zx_mem_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          ce_i,
    input  logic          iorq_i,
    input  logic          mreq_i,
    input  logic          wr_i,
    input  logic          m1_i,
    input  logic [15:0]   a_i,
    input  logic [7:0]    d_i,
    output logic          conmem_o,
    output logic          mapram_o,
    output logic [DW-1:0] bank_o,
    output logic          automap_o
);

    am_state_e     state_q, state_d;
    logic          conmem_q, mapram_q;
    logic [DW-1:0] bank_q;

    logic w_fetch, w_entry, w_unmap, w_rom3d, w_port_wr;
    logic w_unused_d;

    assign w_unused_d = ^d_i;
    assign w_fetch    = ~mreq_i & ~m1_i;
    assign w_unmap    = (a_i[15:3] == 13'h03FF);
    assign w_rom3d    = (a_i[15:8] == 8'h3D);
    assign w_port_wr  = ~iorq_i & ~wr_i & (a_i[7:0] == DIV_PORT);

    always_comb begin
        w_entry = 1'b0;
        for (int i = 0; i < AM_ENTRY_N; i++) begin
            if (a_i == AM_ENTRY[i]) w_entry = 1'b1;
        end
    end

    // Entry points take priority over the unmap range, which takes priority
    // over the instant-map 3Dxx range.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AM_IDLE: begin
                if (w_fetch & w_entry)      state_d = AM_ARMED;
                else if (w_fetch & w_rom3d) state_d = AM_MAPPED;
            end
            AM_ARMED:  if (m1_i) state_d = AM_MAPPED;
            AM_MAPPED: if (w_fetch & ~w_entry & w_unmap) state_d = AM_UNARM;
            AM_UNARM:  if (m1_i) state_d = AM_IDLE;
            default:   state_d = AM_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= AM_IDLE;
            conmem_q <= 1'b0;
            mapram_q <= 1'b0;
            bank_q   <= '0;
        end else if (ce_i) begin
            state_q <= state_d;
            if (w_port_wr) begin
                conmem_q <= d_i[7];
                bank_q   <= d_i[DW-1:0];
                mapram_q <= mapram_q | d_i[6];
            end
        end
    end

    // The 3Dxx fetch itself must already read divMMC, so it is decoded
    // straight from the bus rather than waiting for the state update.
    assign automap_o = (state_q == AM_MAPPED) | (state_q == AM_UNARM) |
                       ((state_q == AM_IDLE) & w_fetch & w_rom3d & ~w_entry);
    assign conmem_o  = conmem_q;
    assign mapram_o  = mapram_q;
    assign bank_o    = bank_q;

endmodule
`default_nettype wire

// File: rtl/zx_memory_mapper.sv
`default_nettype none
// ============================================================================
// Module      : zx_memory_mapper
// Description : Spectrum paging unit for 48K / 128K / +2A/+3 / Pentagon.
//               Decodes the Z80 bus into ROM, RAM and divMMC addresses and
//               drives video page, contention and +3 motor.
// Ports       : clock_i, reset_i, ce_i, mode_i, nomap_i, Z80 strobes
//               (active-low), a_i, d_i; rom_sel_o, div_sel_o, phys_a_o,
//               rom_a_o, mem_we_o, vdu_page_o, contended_o, motor_o.
// Revision    : 1.0  initial release
// ============================================================================
module zx_memory_mapper
    import zx_mem_pkg::*;
#(
    parameter  int RAM_PAGES = 8,
    parameter  int DIV_PAGES = 16,
    parameter  int AUTOMAP   = 1,
    localparam int PW        = $clog2(RAM_PAGES),
    localparam int DW        = $clog2(DIV_PAGES)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          ce_i,
    input  logic [1:0]    mode_i,
    input  logic          nomap_i,
    input  logic          iorq_i,
    input  logic          mreq_i,
    input  logic          wr_i,
    input  logic          m1_i,
    input  logic [15:0]   a_i,
    input  logic [7:0]    d_i,
    output logic          rom_sel_o,
    output logic          div_sel_o,
    output logic [PW+13:0] phys_a_o,
    output logic [15:0]   rom_a_o,
    output logic          mem_we_o,
    output logic          vdu_page_o,
    output logic          contended_o,
    output logic          motor_o
);

    logic [1:0]    mode_q;
    logic [PW-1:0] page_q;
    logic          vdu_q, romlo_q, lock_q;
    logic [3:0]    p1ffd_q;

    logic          w_clr, w_io_wr, w_wr_7ffd, w_wr_1ffd;
    logic [4:0]    w_page_ext;
    logic          w_conmem, w_mapram, w_automap;
    logic [DW-1:0] w_div_bank;
    logic [1:0]    w_slot, w_rom_bank;
    logic          w_special, w_div_hit, w_rom, w_cont;
    logic [PW-1:0] w_page;
    logic [DW+12:0] w_div_addr;

    // A mode switch behaves like a reset of all paging state.
    assign w_clr   = reset_i | (mode_i != mode_q);
    assign w_io_wr = ~iorq_i & ~wr_i;

    assign w_wr_7ffd = w_io_wr & ~a_i[15] & ~a_i[1] & ~lock_q &
                       (mode_i != MODE_48) & ((mode_i != MODE_P2A) | a_i[14]);
    assign w_wr_1ffd = w_io_wr & (mode_i == MODE_P2A) &
                       (a_i[15:12] == 4'b0001) & ~a_i[1] & ~lock_q;

    // Pentagon extends the page with d[7:6]; truncation to PW drops bits
    // the configured RAM cannot address.
    assign w_page_ext = (mode_i == MODE_PENT) ? {d_i[7:6], d_i[2:0]}
                                              : {2'b00, d_i[2:0]};

    always_ff @(posedge clock_i) begin
        mode_q <= mode_i;
        if (w_clr) begin
            page_q  <= '0;
            vdu_q   <= 1'b0;
            romlo_q <= 1'b0;
            lock_q  <= 1'b0;
            p1ffd_q <= 4'h0;
        end else if (ce_i) begin
            if (w_wr_7ffd) begin
                page_q  <= w_page_ext[PW-1:0];
                vdu_q   <= d_i[3];
                romlo_q <= d_i[4];
                lock_q  <= d_i[5];
            end
            if (w_wr_1ffd) p1ffd_q <= d_i[3:0];
        end
    end

    generate
        if (AUTOMAP != 0) begin : g_automap
            divmmc_automap #(.DW(DW)) u_automap (
                .clock_i   (clock_i),
                .reset_i   (w_clr),
                .ce_i      (ce_i),
                .iorq_i    (iorq_i),
                .mreq_i    (mreq_i),
                .wr_i      (wr_i),
                .m1_i      (m1_i),
                .a_i       (a_i),
                .d_i       (d_i),
                .conmem_o  (w_conmem),
                .mapram_o  (w_mapram),
                .bank_o    (w_div_bank),
                .automap_o (w_automap)
            );
        end else begin : g_no_automap
            logic          conmem_q, mapram_q;
            logic [DW-1:0] bank_q;
            logic          w_unused_m1;
            assign w_unused_m1 = m1_i;
            always_ff @(posedge clock_i) begin
                if (w_clr) begin
                    conmem_q <= 1'b0;
                    mapram_q <= 1'b0;
                    bank_q   <= '0;
                end else if (ce_i && w_io_wr && (a_i[7:0] == DIV_PORT)) begin
                    conmem_q <= d_i[7];
                    bank_q   <= d_i[DW-1:0];
                    mapram_q <= mapram_q | d_i[6];
                end
            end
            assign w_conmem   = conmem_q;
            assign w_mapram   = mapram_q;
            assign w_div_bank = bank_q;
            assign w_automap  = 1'b0;
        end
    endgenerate

    assign w_slot    = a_i[15:14];
    assign w_special = (mode_i == MODE_P2A) & p1ffd_q[0];
    assign w_div_hit = (w_conmem | (w_automap & ~nomap_i)) & (w_slot == 2'd0);
    assign w_rom     = ~w_special & (w_slot == 2'd0) & ~w_div_hit;

    always_comb begin
        w_page = '0;
        if (w_special) begin
            w_page = PW'(special_page(p1ffd_q[2:1], w_slot));
        end else begin
            case (w_slot)
                2'd1:    w_page = PW'(3'd5);
                2'd2:    w_page = PW'(3'd2);
                2'd3:    w_page = (mode_i == MODE_48) ? '0 : page_q;
                default: w_page = '0;
            endcase
        end
    end

    always_comb begin
        case (mode_i)
            MODE_P2A: w_rom_bank = {p1ffd_q[2], romlo_q};
            MODE_48:  w_rom_bank = 2'b00;
            default:  w_rom_bank = {1'b0, romlo_q};
        endcase
    end

    // Lower 8K: divMMC ROM, or RAM bank 3 when mapram is set.
    always_comb begin
        if (a_i[13])       w_div_addr = {w_div_bank, a_i[12:0]};
        else if (w_mapram) w_div_addr = {DW'(3), a_i[12:0]};
        else               w_div_addr = {{DW{1'b0}}, a_i[12:0]};
    end

    always_comb begin
        w_cont = 1'b0;
        if (!w_rom && !w_div_hit) begin
            case (mode_i)
                MODE_48:  w_cont = (w_slot == 2'd1);
                MODE_P2A: w_cont = (w_page[PW-1:2] == (PW-2)'(1));
                default:  w_cont = w_page[0];
            endcase
        end
    end

    assign phys_a_o    = w_div_hit ? (PW+14)'(w_div_addr) : {w_page, a_i[13:0]};
    assign rom_a_o     = {w_rom_bank, a_i[13:0]};
    assign rom_sel_o   = w_rom;
    assign div_sel_o   = w_div_hit;
    assign mem_we_o    = ~mreq_i & ~wr_i & ~w_rom & ~(w_div_hit & ~a_i[13]);
    assign vdu_page_o  = vdu_q;
    assign contended_o = w_cont;
    assign motor_o     = p1ffd_q[3];

endmodule
`default_nettype wire
